// File: rtl/uart_rx_os_if.sv
// Byte-delivery handshake between the oversampling UART receiver and the register/FIFO layer.
// The receiver drives the byte, its error flags and the overrun pulse; the consumer drives ready.
interface uart_rx_os_if;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       break_o;
    logic       overrun_o;

    modport master (
        output data_o,
        output valid_o,
        output parity_err_o,
        output frame_err_o,
        output break_o,
        output overrun_o,
        input  ready_i
    );

    modport slave (
        input  data_o,
        input  valid_o,
        input  parity_err_o,
        input  frame_err_o,
        input  break_o,
        input  overrun_o,
        output ready_i
    );
endinterface

// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver: 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// Received bytes are held in an output register and offered through a valid/ready handshake.
module uart_rx_os #(
    parameter logic [7:0] OVERSAMPLE  = 8'd16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   baud_div,
    input  logic [1:0]    parity,
    input  logic          stop2,
    input  logic          rx_i,
    uart_rx_os_if.master  host
);
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, STOP2} state_t;

    localparam logic [7:0] HALF = (OVERSAMPLE >> 1) - 8'd1;
    localparam logic [7:0] FULL = OVERSAMPLE - 8'd1;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic [15:0]            div;
    logic                   tick;
    logic [7:0]             os;
    logic [2:0]             bitn;
    logic [7:0]             sh;
    logic                   perr;
    logic                   ferr;
    logic                   armed;
    logic                   done;
    logic                   ferr_final;
    logic                   par_expect;

    logic [7:0]             out_data;
    logic                   out_valid;
    logic                   out_perr;
    logic                   out_ferr;
    logic                   out_brk;
    logic                   out_overrun;

    assign rx_s       = sync[SYNC_STAGES-1];
    assign ferr_final = ferr | ~rx_s;
    assign par_expect = (parity == 2'd1) ? ^sh : ~^sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div  <= 16'd0;
            tick <= 1'b0;
        end else if (div == 16'd0) begin
            div  <= baud_div;
            tick <= 1'b1;
        end else begin
            div  <= div - 16'd1;
            tick <= 1'b0;
        end
    end

    // Finishing at the final stop mid-sample leaves half a bit to resync on back-to-back frames;
    // after a framing error the line must go high again before another start is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            os    <= 8'd0;
            bitn  <= 3'd0;
            sh    <= 8'd0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            armed <= 1'b1;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (armed && !rx_s) begin
                            state <= START;
                            os    <= HALF;
                        end else if (rx_s) begin
                            armed <= 1'b1;
                        end
                    end
                    START: begin
                        if (os != 8'd0) begin
                            os <= os - 8'd1;
                        end else if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state <= DATA;
                            os    <= FULL;
                            bitn  <= 3'd0;
                            perr  <= 1'b0;
                            ferr  <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (os != 8'd0) begin
                            os <= os - 8'd1;
                        end else begin
                            sh   <= {rx_s, sh[7:1]};
                            os   <= FULL;
                            bitn <= bitn + 3'd1;
                            if (bitn == 3'd7) begin
                                state <= (parity != 2'd0) ? PAR : STOP;
                            end
                        end
                    end
                    PAR: begin
                        if (os != 8'd0) begin
                            os <= os - 8'd1;
                        end else begin
                            perr  <= (rx_s != par_expect);
                            os    <= FULL;
                            state <= STOP;
                        end
                    end
                    STOP: begin
                        if (os != 8'd0) begin
                            os <= os - 8'd1;
                        end else begin
                            ferr <= ferr_final;
                            if (stop2) begin
                                os    <= FULL;
                                state <= STOP2;
                            end else begin
                                state <= IDLE;
                                armed <= ~ferr_final;
                                done  <= 1'b1;
                            end
                        end
                    end
                    STOP2: begin
                        if (os != 8'd0) begin
                            os <= os - 8'd1;
                        end else begin
                            ferr  <= ferr_final;
                            state <= IDLE;
                            armed <= ~ferr_final;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // A finished frame is only dropped when the held byte is still pending and not being taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data    <= 8'd0;
            out_valid   <= 1'b0;
            out_perr    <= 1'b0;
            out_ferr    <= 1'b0;
            out_brk     <= 1'b0;
            out_overrun <= 1'b0;
        end else begin
            out_overrun <= 1'b0;
            if (done) begin
                if (!out_valid || host.ready_i) begin
                    out_data  <= sh;
                    out_perr  <= perr;
                    out_ferr  <= ferr;
                    out_brk   <= ferr && (sh == 8'h00);
                    out_valid <= 1'b1;
                end else begin
                    out_overrun <= 1'b1;
                end
            end else if (out_valid && host.ready_i) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign host.data_o       = out_data;
    assign host.valid_o      = out_valid;
    assign host.parity_err_o = out_perr;
    assign host.frame_err_o  = out_ferr;
    assign host.break_o      = out_brk;
    assign host.overrun_o    = out_overrun;
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: serial frames are driven bit by bit at the receiver's baud rate.
// Inputs change 1 time unit after the rising edge; the handshake monitor samples on the falling edge.
module tb_uart_rx_os;
    localparam int BAUD_DIV = 3;
    localparam int BIT_CLKS = 16 * (BAUD_DIV + 1);

    logic        clk;
    logic        rst;
    logic [15:0] baud_div;
    logic [1:0]  parity;
    logic        stop2;
    logic        rx;

    int checks;
    int errors;
    int accept_count;
    int accept_err_count;
    int overrun_count;
    logic [7:0] acc_data;
    logic       acc_perr;
    logic       acc_ferr;
    logic       acc_brk;
    int base_acc;
    int base_err;
    int base_ovr;

    uart_rx_os_if bus_if ();

    uart_rx_os dut (
        .clk      (clk),
        .rst      (rst),
        .baud_div (baud_div),
        .parity   (parity),
        .stop2    (stop2),
        .rx_i     (rx),
        .host     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.valid_o && bus_if.ready_i) begin
            accept_count = accept_count + 1;
            acc_data = bus_if.data_o;
            acc_perr = bus_if.parity_err_o;
            acc_ferr = bus_if.frame_err_o;
            acc_brk  = bus_if.break_o;
            if (bus_if.parity_err_o || bus_if.frame_err_o) begin
                accept_err_count = accept_err_count + 1;
            end
        end
        if (bus_if.overrun_o) begin
            overrun_count = overrun_count + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) step();
    endtask

    task automatic apply_stimulus(input logic [7:0] d, input logic [1:0] pmode,
                                  input logic bad_par, input logic two_stop);
        logic p;
        parity = pmode;
        stop2  = two_stop;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pmode != 2'd0) begin
            p = (pmode == 2'd1) ? ^d : ~^d;
            drive_bit(p ^ bad_par);
        end
        drive_bit(1'b1);
        if (two_stop) drive_bit(1'b1);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected) else begin
            errors = errors + 1;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic accept_one();
        bus_if.ready_i = 1'b1;
        step();
        bus_if.ready_i = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        accept_count = 0;
        accept_err_count = 0;
        overrun_count = 0;
        acc_data = 8'h00;
        acc_perr = 1'b0;
        acc_ferr = 1'b0;
        acc_brk  = 1'b0;
        rst = 1'b1;
        baud_div = 16'(BAUD_DIV);
        parity = 2'd0;
        stop2 = 1'b0;
        rx = 1'b1;
        bus_if.ready_i = 1'b0;

        repeat (3) step();
        check_output("reset_valid", 32'(bus_if.valid_o), 32'd0);
        check_output("reset_data", 32'(bus_if.data_o), 32'h00);
        check_output("reset_flags", {29'd0, bus_if.parity_err_o, bus_if.frame_err_o, bus_if.break_o}, 32'd0);
        check_output("reset_overrun", 32'(bus_if.overrun_o), 32'd0);
        rst = 1'b0;
        drive_bit(1'b1);

        apply_stimulus(8'hA5, 2'd0, 1'b0, 1'b0);
        check_output("a5_valid", 32'(bus_if.valid_o), 32'd1);
        check_output("a5_data", 32'(bus_if.data_o), 32'hA5);
        check_output("a5_flags", {29'd0, bus_if.parity_err_o, bus_if.frame_err_o, bus_if.break_o}, 32'd0);
        accept_one();
        check_output("a5_accept_valid", 32'(bus_if.valid_o), 32'd0);
        check_output("a5_hold_data", 32'(bus_if.data_o), 32'hA5);

        apply_stimulus(8'h07, 2'd1, 1'b1, 1'b0);
        check_output("par_bad_data", 32'(bus_if.data_o), 32'h07);
        check_output("par_bad_perr", 32'(bus_if.parity_err_o), 32'd1);
        accept_one();
        apply_stimulus(8'h07, 2'd1, 1'b0, 1'b0);
        check_output("par_ok_valid", 32'(bus_if.valid_o), 32'd1);
        check_output("par_ok_perr", 32'(bus_if.parity_err_o), 32'd0);
        accept_one();

        parity = 2'd0;
        rx = 1'b0;
        repeat (4 * (BAUD_DIV + 1)) step();
        drive_bit(1'b1);
        drive_bit(1'b1);
        check_output("glitch_no_valid", 32'(bus_if.valid_o), 32'd0);
        apply_stimulus(8'h3C, 2'd0, 1'b0, 1'b0);
        check_output("after_glitch_data", 32'(bus_if.data_o), 32'h3C);
        check_output("after_glitch_flags", {29'd0, bus_if.parity_err_o, bus_if.frame_err_o, bus_if.break_o}, 32'd0);
        accept_one();

        bus_if.ready_i = 1'b1;
        base_acc = accept_count;
        rx = 1'b0;
        repeat (30 * BIT_CLKS) step();
        drive_bit(1'b1);
        drive_bit(1'b1);
        check_output("break_frames", 32'(accept_count - base_acc), 32'd1);
        check_output("break_data", 32'(acc_data), 32'h00);
        check_output("break_ferr", 32'(acc_ferr), 32'd1);
        check_output("break_flag", 32'(acc_brk), 32'd1);
        base_acc = accept_count;
        apply_stimulus(8'h55, 2'd0, 1'b0, 1'b0);
        drive_bit(1'b1);
        check_output("post_break_frames", 32'(accept_count - base_acc), 32'd1);
        check_output("post_break_data", 32'(acc_data), 32'h55);
        check_output("post_break_ferr", 32'(acc_ferr), 32'd0);

        bus_if.ready_i = 1'b0;
        base_ovr = overrun_count;
        apply_stimulus(8'h11, 2'd0, 1'b0, 1'b0);
        apply_stimulus(8'h22, 2'd0, 1'b0, 1'b0);
        check_output("ovr_valid", 32'(bus_if.valid_o), 32'd1);
        check_output("ovr_data", 32'(bus_if.data_o), 32'h11);
        check_output("ovr_pulse_clks", 32'(overrun_count - base_ovr), 32'd1);
        accept_one();
        check_output("ovr_drain_valid", 32'(bus_if.valid_o), 32'd0);

        bus_if.ready_i = 1'b1;
        base_acc = accept_count;
        base_err = accept_err_count;
        for (int n = 0; n < 3; n++) apply_stimulus(8'hFF, 2'd2, 1'b0, 1'b1);
        drive_bit(1'b1);
        check_output("b2b_frames", 32'(accept_count - base_acc), 32'd3);
        check_output("b2b_errors", 32'(accept_err_count - base_err), 32'd0);
        check_output("b2b_data", 32'(acc_data), 32'hFF);

        base_acc = accept_count;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rst = 1'b1;
        step();
        step();
        check_output("rst_mid_valid", 32'(bus_if.valid_o), 32'd0);
        check_output("rst_mid_data", 32'(bus_if.data_o), 32'h00);
        rst = 1'b0;
        rx = 1'b1;
        drive_bit(1'b1);
        drive_bit(1'b1);
        check_output("rst_mid_no_frame", 32'(accept_count - base_acc), 32'd0);
        base_err = accept_err_count;
        apply_stimulus(8'h5A, 2'd2, 1'b0, 1'b1);
        drive_bit(1'b1);
        check_output("after_rst_frames", 32'(accept_count - base_acc), 32'd1);
        check_output("after_rst_data", 32'(acc_data), 32'h5A);
        check_output("after_rst_errors", 32'(accept_err_count - base_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
